// File: rtl/alu_bist_driver.sv
// Self-test initiator for the 4-bit ALU: sweeps all 1024 {F,X,Y} vectors, checks each
// result against a golden model after SETTLE_CYCLES, and keeps an error count plus the first failing index.
module alu_bist_driver #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] alu_result,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic [1:0] f_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [9:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [9:0] r_vec;
  logic [3:0] r_settle;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [1:0] r_f;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_err;
  logic [9:0] r_ffv;
  logic       r_ffvld;

  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [3:0] w_golden;
  logic       w_mismatch;
  logic [9:0] w_vec_nxt;

  assign w_x = r_vec[7:4];
  assign w_y = r_vec[3:0];

  always_comb begin
    w_golden = 4'h0;
    unique case (r_vec[9:8])
      2'b00:   w_golden = w_x + w_y;
      2'b01:   w_golden = w_x + ~w_y + 4'd1;
      2'b10:   w_golden = w_x ^ w_y;
      default: w_golden = ~(w_x ^ w_y);
    endcase
  end

  assign w_mismatch = (alu_result != w_golden);
  assign w_vec_nxt  = r_vec + 10'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_vec    <= 10'd0;
      r_settle <= 4'd0;
      r_x      <= 4'd0;
      r_y      <= 4'd0;
      r_f      <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 8'd0;
      r_ffv    <= 10'd0;
      r_ffvld  <= 1'b0;
    end else if (abort) begin
      // Abort drops the sweep but keeps the results gathered so far.
      r_state  <= S_IDLE;
      r_vec    <= 10'd0;
      r_settle <= 4'd0;
      r_x      <= 4'd0;
      r_y      <= 4'd0;
      r_f      <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_SETTLE;
            r_vec    <= 10'd0;
            r_settle <= 4'd0;
            r_x      <= 4'd0;
            r_y      <= 4'd0;
            r_f      <= 2'd0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 8'd0;
            r_ffv    <= 10'd0;
            r_ffvld  <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_settle == LP_SETTLE_LAST) begin
            r_state  <= S_CHECK;
            r_settle <= 4'd0;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (!r_ffvld) begin
              r_ffv   <= r_vec;
              r_ffvld <= 1'b1;
            end
          end
          if (r_vec == 10'h3FF) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_SETTLE;
            r_vec   <= w_vec_nxt;
            r_f     <= w_vec_nxt[9:8];
            r_x     <= w_vec_nxt[7:4];
            r_y     <= w_vec_nxt[3:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_out            = r_x;
  assign y_out            = r_y;
  assign f_out            = r_f;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err_count        = r_err;
  assign first_fail_vec   = r_ffv;
  assign first_fail_valid = r_ffvld;
  assign pass             = r_done && (r_err == 8'd0);

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: a behavioural ALU with selectable faults feeds the DUT,
// and a per-index reference sweep predicts error count and first failing vector.
module tb_alu_bist_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] alu_result;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic [1:0] f_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [9:0] first_fail_vec;
  logic       first_fail_valid;

  int         mode;
  logic [3:0] fault_mask [1024];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  alu_bist_driver #(.SETTLE_CYCLES(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .alu_result       (alu_result),
    .x_out            (x_out),
    .y_out            (y_out),
    .f_out            (f_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  function automatic logic [3:0] golden(input logic [9:0] v);
    int xi = int'(v[7:4]);
    int yi = int'(v[3:0]);
    case (v[9:8])
      2'd0:    return 4'((xi + yi) % 16);
      2'd1:    return 4'((xi - yi + 16) % 16);
      2'd2:    return v[7:4] ^ v[3:0];
      default: return ~(v[7:4] ^ v[3:0]);
    endcase
  endfunction

  // mode 0: healthy, 1: OUT[0] stuck low, 2: F=11 misses invert, 3: per-vector XOR mask
  function automatic logic [3:0] alu_fn(input int m, input logic [9:0] v);
    logic [3:0] g = golden(v);
    case (m)
      1:       return g & 4'hE;
      2:       return (v[9:8] == 2'b11) ? (v[7:4] ^ v[3:0]) : g;
      3:       return g ^ fault_mask[v];
      default: return g;
    endcase
  endfunction

  assign alu_result = alu_fn(mode, {f_out, x_out, y_out});

  task automatic ref_run(input int m, input int nvec, output int cnt, output int first, output bit valid);
    int raw = 0;
    first = 0;
    valid = 1'b0;
    for (int i = 0; i < nvec; i++) begin
      if (alu_fn(m, 10'(i)) !== golden(10'(i))) begin
        if (!valid) begin
          first = i;
          valid = 1'b1;
        end
        raw++;
      end
    end
    cnt = (raw > 255) ? 255 : raw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the first negedge after the start-accept edge; extra_at re-pulses start mid-sweep.
  task automatic wait_done(input string tag, input int extra_at);
    int vbad = 0;
    int dcyc = -1;
    for (int k = 0; k < 4000; k++) begin
      if (done) begin
        dcyc = k;
        break;
      end
      if (k < 3072 && ({f_out, x_out, y_out} !== 10'(k / 3) || busy !== 1'b1)) vbad++;
      start = (k == extra_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_vector_seq"}, vbad, 0);
    chk({tag, "_done_cycle"}, dcyc, 3072);
  endtask

  task automatic check_done(input string tag, input int m);
    int  cnt;
    int  first;
    bit  valid;
    ref_run(m, 1024, cnt, first, valid);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_count, cnt);
    chk({tag, "_ffv"}, first_fail_vec, first);
    chk({tag, "_ffvld"}, first_fail_valid, valid);
    chk({tag, "_pass"}, pass, (cnt == 0));
    chk({tag, "_hold_vec"}, {f_out, x_out, y_out}, 10'h3FF);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_xyf"}, {f_out, x_out, y_out}, 0);
  endtask

  initial begin
    int cnt;
    int first;
    bit valid;
    int nf;
    int idx;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    for (int i = 0; i < 1024; i++) fault_mask[i] = 4'h0;

    #12;
    check_quiet("reset");
    chk("reset_err", err_count, 0);
    chk("reset_ffv", {first_fail_valid, first_fail_vec}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("idle_after_reset");

    // Healthy ALU: clean pass
    mode = 0;
    start_pulse();
    wait_done("healthy", -1);
    check_done("healthy", 0);

    // Stuck OUT[0] plus an ignored start at cycle 100
    mode = 1;
    start_pulse();
    wait_done("stuck0", 100);
    check_done("stuck0", 1);
    chk("stuck0_sat", err_count, 8'd255);
    chk("stuck0_first", first_fail_vec, 10'h001);

    // Missing invert for F=11
    mode = 2;
    start_pulse();
    wait_done("noinv", -1);
    check_done("noinv", 2);
    chk("noinv_sat", err_count, 8'd255);
    chk("noinv_first", first_fail_vec, 10'h300);

    // Abort during SETTLE of vector 166: vectors 0..165 have been checked
    mode = 1;
    start_pulse();
    repeat (499) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_quiet("abort");
    ref_run(1, 166, cnt, first, valid);
    chk("abort_err_kept", err_count, cnt);
    chk("abort_ffv_kept", {first_fail_valid, first_fail_vec}, {valid, 10'(first)});
    repeat (10) @(negedge clk);
    check_quiet("abort_stays_idle");

    // Asynchronous reset mid-sweep
    start_pulse();
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("async_rst");
    chk("async_rst_err", err_count, 0);
    chk("async_rst_ffv", {first_fail_valid, first_fail_vec}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_quiet("post_rst_idle");

    // Exactly five random faulty vectors
    mode = 3;
    nf = 0;
    while (nf < 5) begin
      idx = int'($urandom_range(0, 1023));
      if (fault_mask[idx] == 4'h0) begin
        fault_mask[idx] = 4'($urandom_range(1, 15));
        nf++;
      end
    end
    start_pulse();
    wait_done("rand5", -1);
    check_done("rand5", 3);
    chk("rand5_count", err_count, 5);

    // Restart from DONE with a denser random fault map
    for (int i = 0; i < 1024; i++)
      fault_mask[i] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    start_pulse();
    chk("restart_err_clr", err_count, 0);
    chk("restart_ffvld_clr", first_fail_valid, 0);
    chk("restart_ffv_clr", first_fail_vec, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    wait_done("randmap", -1);
    check_done("randmap", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
